// File: rtl/pcileech_sysctl.sv
// -----------------------------------------------------------------------------
// pcileech_sysctl
//
// Board housekeeping shared by every PCILeech FPGA top level:
//   - power-on / requested reset stretching (rst_out is the design-wide reset),
//   - free-running 64-bit cycle counter,
//   - button synchronisation and (optional) debounce, with per-button reset,
//   - LED drivers with off / on / heartbeat / activity modes.
//
// Build option:
//   PCILEECH_SYSCTL_DEBOUNCE_EN  defined   -> per-button debounce counters;
//                                  undefined -> btn_out is the 2-flop
//                                               synchronised raw input.
//
// Ports:
//   clk          in   system clock (100 MHz), sole clock domain
//   rst          in   synchronous active-high reset request
//   btn_in       in   raw asynchronous button pads, active-high
//   led_mode     in   2 bits per LED: 00 off, 01 on, 10 heartbeat, 11 activity
//   led_act      in   per-LED activity pulse
//   led_invert   in   global LED polarity invert
//   btn_out      out  debounced (or synchronised) button level
//   rst_out      out  stretched system reset, active-high, registered
//   tickcount64  out  free-running cycle count
//   led          out  registered LED drive
//
// Power-up values come from register declarations (FPGA configuration
// values): rst_out high, counters zero, LEDs all on.
// -----------------------------------------------------------------------------
module pcileech_sysctl #(
    parameter int                         PARAM_LED_COUNT     = 3,
    parameter int                         PARAM_BTN_COUNT     = 2,
    parameter logic [PARAM_BTN_COUNT-1:0] PARAM_BTN_RST_MASK  = 2'b10,
    parameter int                         PARAM_RST_CYCLES    = 64,
    parameter int                         PARAM_DEBOUNCE_BITS = 16,
    parameter int                         PARAM_BLINK_BIT     = 26,
    parameter int                         PARAM_STRETCH_BITS  = 22
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PARAM_BTN_COUNT-1:0]   btn_in,
    input  logic [2*PARAM_LED_COUNT-1:0] led_mode,
    input  logic [PARAM_LED_COUNT-1:0]   led_act,
    input  logic                         led_invert,
    output logic [PARAM_BTN_COUNT-1:0]   btn_out,
    output logic                         rst_out,
    output logic [63:0]                  tickcount64,
    output logic [PARAM_LED_COUNT-1:0]   led
);

    localparam int RCNT_W = $clog2(PARAM_RST_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RCNT_MAX  = RCNT_W'(PARAM_RST_CYCLES);
    localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1'b1);
    localparam logic [RCNT_W-1:0] RCNT_ZERO = {RCNT_W{1'b0}};

    localparam logic [PARAM_STRETCH_BITS-1:0] SCNT_FULL = {PARAM_STRETCH_BITS{1'b1}};
    localparam logic [PARAM_STRETCH_BITS-1:0] SCNT_ONE  = PARAM_STRETCH_BITS'(1'b1);
    localparam logic [PARAM_STRETCH_BITS-1:0] SCNT_ZERO = {PARAM_STRETCH_BITS{1'b0}};

    // Registered state with power-up values.
    logic [RCNT_W-1:0]             rcnt_r    = RCNT_ZERO;
    logic                          rst_out_r = 1'b1;
    logic [63:0]                   tick_r    = 64'd0;
    logic [PARAM_BTN_COUNT-1:0]    sync1_r   = {PARAM_BTN_COUNT{1'b0}};
    logic [PARAM_BTN_COUNT-1:0]    btn_out_r = {PARAM_BTN_COUNT{1'b0}};
    logic [PARAM_STRETCH_BITS-1:0] scnt_r [PARAM_LED_COUNT] = '{default: SCNT_ZERO};
    logic [PARAM_LED_COUNT-1:0]    led_r     = {PARAM_LED_COUNT{1'b1}};

    // Combinational helpers.
    logic                       req_s;
    logic [RCNT_W-1:0]          rcnt_next_s;
    logic [PARAM_LED_COUNT-1:0] led_f_s;
    logic [PARAM_LED_COUNT-1:0] led_next_s;

    // ------------------------------------------------------------------
    // Reset stretching
    // ------------------------------------------------------------------

    // Merge external and button reset requests; next stretch count saturates.
    always_comb begin
        req_s = rst | (|(btn_out_r & PARAM_BTN_RST_MASK));
        if (req_s) begin
            rcnt_next_s = RCNT_ZERO;
        end else if (rcnt_r >= RCNT_MAX) begin
            rcnt_next_s = RCNT_MAX;
        end else begin
            rcnt_next_s = rcnt_r + RCNT_ONE;
        end
    end

    // Stretch counter and registered reset output; a new request mid-stretch
    // restarts the count while rst_out stays high, so no glitch is possible.
    always_ff @(posedge clk) begin
        rcnt_r    <= rcnt_next_s;
        rst_out_r <= req_s | (rcnt_next_s < RCNT_MAX);
    end

    // ------------------------------------------------------------------
    // Tick counter
    // ------------------------------------------------------------------

    // Free-running cycle counter; only the external request clears it so that
    // a button reset does not disturb timestamps.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= 64'd0;
        end else begin
            tick_r <= tick_r + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // Buttons (never reset: the button itself may be the reset source)
    // ------------------------------------------------------------------
`ifdef PCILEECH_SYSCTL_DEBOUNCE_EN
    localparam int DB_W = PARAM_DEBOUNCE_BITS;
    localparam logic [DB_W-1:0] DCNT_FULL = {DB_W{1'b1}};
    localparam logic [DB_W-1:0] DCNT_ONE  = DB_W'(1'b1);
    localparam logic [DB_W-1:0] DCNT_ZERO = {DB_W{1'b0}};

    logic [PARAM_BTN_COUNT-1:0] sync2_r = {PARAM_BTN_COUNT{1'b0}};
    logic [DB_W-1:0]            dcnt_r [PARAM_BTN_COUNT] = '{default: DCNT_ZERO};

    // Two-flop synchroniser for the asynchronous pads.
    always_ff @(posedge clk) begin
        sync1_r <= btn_in;
        sync2_r <= sync1_r;
    end

    // Debounce: count cycles the synced level differs from btn_out; accept the
    // new level once the counter has been all-ones, any reversion restarts.
    always_ff @(posedge clk) begin
        for (int b = 0; b < PARAM_BTN_COUNT; b++) begin
            if (sync2_r[b] == btn_out_r[b]) begin
                dcnt_r[b] <= DCNT_ZERO;
            end else if (dcnt_r[b] == DCNT_FULL) begin
                btn_out_r[b] <= sync2_r[b];
                dcnt_r[b]    <= DCNT_ZERO;
            end else begin
                dcnt_r[b] <= dcnt_r[b] + DCNT_ONE;
            end
        end
    end
`else
    // Debounce width has no role without the debounce counters.
    logic [31:0] unused_debounce_bits_s;
    assign unused_debounce_bits_s = 32'(PARAM_DEBOUNCE_BITS);

    // Two-flop synchroniser; the second flop is the button output itself.
    always_ff @(posedge clk) begin
        sync1_r   <= btn_in;
        btn_out_r <= sync1_r;
    end
`endif

    // ------------------------------------------------------------------
    // LEDs
    // ------------------------------------------------------------------

    // Activity stretch counters: reload on a pulse, otherwise run down to zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PARAM_LED_COUNT; i++) begin
            if (rst) begin
                scnt_r[i] <= SCNT_ZERO;
            end else if (led_act[i]) begin
                scnt_r[i] <= SCNT_FULL;
            end else if (scnt_r[i] != SCNT_ZERO) begin
                scnt_r[i] <= scnt_r[i] - SCNT_ONE;
            end else begin
                scnt_r[i] <= SCNT_ZERO;
            end
        end
    end

    // Per-channel lamp function selected by mode, then global polarity.
    always_comb begin
        led_f_s = {PARAM_LED_COUNT{1'b0}};
        for (int i = 0; i < PARAM_LED_COUNT; i++) begin
            case (led_mode[2*i +: 2])
                2'b00:   led_f_s[i] = 1'b0;
                2'b01:   led_f_s[i] = 1'b1;
                2'b10:   led_f_s[i] = tick_r[PARAM_BLINK_BIT];
                2'b11:   led_f_s[i] = (scnt_r[i] != SCNT_ZERO);
                default: led_f_s[i] = 1'b0;
            endcase
        end
        led_next_s = led_f_s ^ {PARAM_LED_COUNT{led_invert}};
    end

    // LED register; all lamps lit during reset regardless of polarity.
    always_ff @(posedge clk) begin
        if (rst_out_r) begin
            led_r <= {PARAM_LED_COUNT{1'b1}};
        end else begin
            led_r <= led_next_s;
        end
    end

    assign btn_out     = btn_out_r;
    assign rst_out     = rst_out_r;
    assign tickcount64 = tick_r;
    assign led         = led_r;

endmodule

// File: tb/tb_pcileech_sysctl.sv
// -----------------------------------------------------------------------------
// tb_pcileech_sysctl
//
// Self-checking bench for pcileech_sysctl (RST_CYCLES=8, DEBOUNCE_BITS=3,
// STRETCH_BITS=3, BLINK_BIT=2, 3 LEDs, 2 buttons, reset mask 2'b10).
// The reference model tracks timestamps: last reset request, last external
// reset, last activity pulse per LED and the raw button sample history, and
// derives every output from those. It follows PCILEECH_SYSCTL_DEBOUNCE_EN.
// -----------------------------------------------------------------------------
module tb_pcileech_sysctl;

    localparam int LEDS  = 3;
    localparam int BTNS  = 2;
    localparam int RSTC  = 8;
    localparam int DBB   = 3;
    localparam int SB    = 3;
    localparam int BLINK = 2;
    localparam int SLAST = (1 << SB) - 1;
    localparam int DWIN  = 1 << DBB;
    localparam int NEVER = -1000000;
    localparam int HMAX  = 4096;
    localparam logic [1:0] RMASK = 2'b10;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic [1:0]  btn_in     = 2'b00;
    logic [5:0]  led_mode   = 6'b000000;
    logic [2:0]  led_act    = 3'b000;
    logic        led_invert = 1'b0;
    logic [1:0]  btn_out;
    logic        rst_out;
    logic [63:0] tickcount64;
    logic [2:0]  led;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          n        = 0;
    int          last_req = 0;
    int          last_rst = 0;
    int          last_act [LEDS];
    logic [1:0]  raw_hist [HMAX];
    logic [1:0]  m_btn_out = 2'b00;
    logic        m_rst_out = 1'b1;
    logic [63:0] m_tick    = 64'd0;
    logic [2:0]  m_led     = 3'b111;

    pcileech_sysctl #(
        .PARAM_LED_COUNT     (LEDS),
        .PARAM_BTN_COUNT     (BTNS),
        .PARAM_BTN_RST_MASK  (RMASK),
        .PARAM_RST_CYCLES    (RSTC),
        .PARAM_DEBOUNCE_BITS (DBB),
        .PARAM_BLINK_BIT     (BLINK),
        .PARAM_STRETCH_BITS  (SB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .led_mode    (led_mode),
        .led_act     (led_act),
        .led_invert  (led_invert),
        .btn_out     (btn_out),
        .rst_out     (rst_out),
        .tickcount64 (tickcount64),
        .led         (led)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] raw_at(input int k);
        if (k < 1 || k >= HMAX) begin
            return 2'b00;
        end
        return raw_hist[k];
    endfunction

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_edge();
        logic       f;
        logic       req;
        logic       w;
        logic       stable;
        logic [1:0] r;
        n = n + 1;
        if (n < HMAX) raw_hist[n] = btn_in;
        for (int i = 0; i < LEDS; i++) begin
            f = 1'b0;
            case (led_mode[2*i +: 2])
                2'b01:   f = 1'b1;
                2'b10:   f = m_tick[BLINK];
                2'b11:   f = (((n - 1) - last_act[i]) < SLAST);
                default: f = 1'b0;
            endcase
            m_led[i] = m_rst_out ? 1'b1 : (f ^ led_invert);
        end
        for (int i = 0; i < LEDS; i++) begin
            if (rst) last_act[i] = NEVER;
            else if (led_act[i]) last_act[i] = n;
        end
        if (rst) last_rst = n;
        m_tick = 64'(n - last_rst);
        req = rst | (|(m_btn_out & RMASK));
        if (req) last_req = n;
        m_rst_out = ((n - last_req) < RSTC);
        for (int b = 0; b < BTNS; b++) begin
`ifdef PCILEECH_SYSCTL_DEBOUNCE_EN
            r = raw_at(n - 2);
            w = r[b];
            stable = 1'b1;
            for (int k = n - 1 - DWIN; k <= n - 2; k++) begin
                r = raw_at(k);
                if (r[b] != w) stable = 1'b0;
            end
            if (stable && (w != m_btn_out[b])) m_btn_out[b] = w;
`else
            stable = 1'b0;
            w = 1'b0;
            r = raw_at(n - 1);
            m_btn_out[b] = r[b];
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (rst_out !== 1'b1) begin bad++; $display("FAIL pwr_rst_out got=%b exp=1", rst_out); end
        total++; if (led !== 3'b111) begin bad++; $display("FAIL pwr_led got=%b exp=111", led); end
        total++; if (tickcount64 !== 64'd0) begin bad++; $display("FAIL pwr_tick got=%0d exp=0", tickcount64); end
        total++; if (btn_out !== 2'b00) begin bad++; $display("FAIL pwr_btn got=%b exp=00", btn_out); end
        repeat (12) begin
            step();
            total++; if (rst_out !== m_rst_out) begin bad++; $display("FAIL pu_rst_out cyc=%0d got=%b exp=%b", n, rst_out, m_rst_out); end
            total++; if (tickcount64 !== m_tick) begin bad++; $display("FAIL pu_tick cyc=%0d got=%0d exp=%0d", n, tickcount64, m_tick); end
            total++; if (led !== m_led) begin bad++; $display("FAIL pu_led cyc=%0d got=%b exp=%b", n, led, m_led); end
            if (n == RSTC - 1) begin
                total++; if (rst_out !== 1'b1) begin bad++; $display("FAIL pu_last_high got=%b exp=1", rst_out); end
            end
            if (n == RSTC) begin
                total++; if (rst_out !== 1'b0) begin bad++; $display("FAIL pu_fall got=%b exp=0", rst_out); end
                total++; if (tickcount64 !== 64'd8) begin bad++; $display("FAIL pu_tick8 got=%0d exp=8", tickcount64); end
            end
        end
    endtask

    task automatic test_rst_request();
        while (n < 40) begin
            rst = ((n + 1 >= 20) && (n + 1 <= 22)) || (n + 1 == 27);
            step();
            total++; if (rst_out !== m_rst_out) begin bad++; $display("FAIL req_rst_out cyc=%0d got=%b exp=%b", n, rst_out, m_rst_out); end
            total++; if (tickcount64 !== m_tick) begin bad++; $display("FAIL req_tick cyc=%0d got=%0d exp=%0d", n, tickcount64, m_tick); end
            if (n == 23) begin
                total++; if (tickcount64 !== 64'd1) begin bad++; $display("FAIL req_tick_restart got=%0d exp=1", tickcount64); end
            end
            if (n == 34) begin
                total++; if (rst_out !== 1'b1) begin bad++; $display("FAIL req_hold34 got=%b exp=1", rst_out); end
            end
            if (n == 35) begin
                total++; if (rst_out !== 1'b0) begin bad++; $display("FAIL req_fall35 got=%b exp=0", rst_out); end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_button_reset();
        int lvl [4];
        int len [4];
        lvl = '{1, 0, 1, 0};
        len = '{5, 15, 20, 30};
        for (int p = 0; p < 4; p++) begin
            btn_in[1] = lvl[p][0];
            repeat (len[p]) begin
                step();
                total++; if (btn_out !== m_btn_out) begin bad++; $display("FAIL btnrst_btn cyc=%0d got=%b exp=%b", n, btn_out, m_btn_out); end
                total++; if (rst_out !== m_rst_out) begin bad++; $display("FAIL btnrst_rst_out cyc=%0d got=%b exp=%b", n, rst_out, m_rst_out); end
                total++; if (tickcount64 !== m_tick) begin bad++; $display("FAIL btnrst_tick cyc=%0d got=%0d exp=%0d", n, tickcount64, m_tick); end
            end
        end
    endtask

    task automatic test_button_plain();
        int lvl [4];
        int len [4];
        lvl = '{1, 0, 1, 0};
        len = '{1, 8, 15, 15};
        for (int p = 0; p < 4; p++) begin
            btn_in[0] = lvl[p][0];
            repeat (len[p]) begin
                step();
                total++; if (btn_out !== m_btn_out) begin bad++; $display("FAIL btn0_btn cyc=%0d got=%b exp=%b", n, btn_out, m_btn_out); end
                total++; if (rst_out !== m_rst_out) begin bad++; $display("FAIL btn0_rst_out cyc=%0d got=%b exp=%b", n, rst_out, m_rst_out); end
            end
        end
    endtask

    task automatic test_leds();
        led_mode = 6'b01_10_11;
        for (int phase = 0; phase < 3; phase++) begin
            led_invert = (phase == 1);
            for (int t = 0; t < 14; t++) begin
                led_act = ((t == 0) || (phase == 2 && t == 4)) ? 3'b001 : 3'b000;
                step();
                total++; if (led !== m_led) begin bad++; $display("FAIL led_dir cyc=%0d got=%b exp=%b", n, led, m_led); end
            end
        end
        led_act = 3'b000;
        repeat (200) begin
            if ($urandom_range(0, 9) == 0) led_mode = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 29) == 0) led_invert = ~led_invert;
            led_act = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step();
            total++; if (led !== m_led) begin bad++; $display("FAIL led_rand cyc=%0d got=%b exp=%b", n, led, m_led); end
        end
        led_act = 3'b000;
    endtask

    task automatic test_random();
        repeat (1500) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int b = 0; b < BTNS; b++) begin
                if ($urandom_range(0, 9) == 0) btn_in[b] = ~btn_in[b];
            end
            if ($urandom_range(0, 19) == 0) led_mode = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 49) == 0) led_invert = ~led_invert;
            led_act = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step();
            total++; if (rst_out !== m_rst_out) begin bad++; $display("FAIL rnd_rst_out cyc=%0d got=%b exp=%b", n, rst_out, m_rst_out); end
            total++; if (tickcount64 !== m_tick) begin bad++; $display("FAIL rnd_tick cyc=%0d got=%0d exp=%0d", n, tickcount64, m_tick); end
            total++; if (btn_out !== m_btn_out) begin bad++; $display("FAIL rnd_btn cyc=%0d got=%b exp=%b", n, btn_out, m_btn_out); end
            total++; if (led !== m_led) begin bad++; $display("FAIL rnd_led cyc=%0d got=%b exp=%b", n, led, m_led); end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < LEDS; i++) last_act[i] = NEVER;
        for (int k = 0; k < HMAX; k++) raw_hist[k] = 2'b00;
        test_reset();
        test_rst_request();
        test_button_reset();
        test_button_plain();
        test_leds();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
